// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: fetch-unit bus bundle.
// master (fetch unit): drives InstrMem_Address, Instruction, OP, InstrValid, PC_plus4, RetiredCount;
//   samples Stall, BranchEQ, BranchNE, Zero, Jump, BranchOffset, JumpTarget, InstrMem_Data, InstrMem_Ready.
// slave (memory/pipeline side): the mirror image.
interface instruction_fetch_unit_if;
    logic        Stall;
    logic        BranchEQ;
    logic        BranchNE;
    logic        Zero;
    logic        Jump;
    logic [31:0] BranchOffset;
    logic [25:0] JumpTarget;
    logic [31:0] InstrMem_Data;
    logic        InstrMem_Ready;
    logic [31:0] InstrMem_Address;
    logic [31:0] Instruction;
    logic [5:0]  OP;
    logic        InstrValid;
    logic [31:0] PC_plus4;
    logic [31:0] RetiredCount;

    modport master (
        input  Stall, BranchEQ, BranchNE, Zero, Jump, BranchOffset, JumpTarget,
               InstrMem_Data, InstrMem_Ready,
        output InstrMem_Address, Instruction, OP, InstrValid, PC_plus4, RetiredCount
    );

    modport slave (
        output Stall, BranchEQ, BranchNE, Zero, Jump, BranchOffset, JumpTarget,
               InstrMem_Data, InstrMem_Ready,
        input  InstrMem_Address, Instruction, OP, InstrValid, PC_plus4, RetiredCount
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: two-state fetch engine that presents one instruction at a time and steps the PC on accept.
// Ports: clk, reset (sync, active-high); bus (master modport) carries memory read, branch/jump controls and outputs.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input logic                        clk,
    input logic                        reset,
    instruction_fetch_unit_if.master   bus
);
    typedef enum logic {FETCH, VALID} state_t;

    state_t      state, nextState;
    logic [31:0] pc, nextPc, pcPlus4, branchTarget, instruction, retiredCount;
    logic        taken, capture, accept;

    assign pcPlus4      = pc + 32'd4;
    assign branchTarget = pcPlus4 + {bus.BranchOffset[29:0], 2'b00};
    // Both branch kinds asserted together always resolve taken, since Zero is either 0 or 1.
    assign taken        = (bus.BranchEQ & bus.Zero) | (bus.BranchNE & ~bus.Zero);
    assign nextPc       = bus.Jump ? {pcPlus4[31:28], bus.JumpTarget, 2'b00} :
                          taken    ? branchTarget : pcPlus4;

    always_comb begin
        nextState = state;
        capture   = 1'b0;
        accept    = 1'b0;
        if (state == FETCH) begin
            capture   = bus.InstrMem_Ready;
            nextState = bus.InstrMem_Ready ? VALID : FETCH;
        end else begin
            accept    = ~bus.Stall;
            nextState = bus.Stall ? VALID : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            instruction  <= 32'd0;
            retiredCount <= 32'd0;
        end else begin
            state <= nextState;
            if (capture) instruction <= bus.InstrMem_Data;
            if (accept) begin
                pc           <= nextPc;
                retiredCount <= retiredCount + 32'd1;
            end
        end
    end

    assign bus.InstrMem_Address = pc;
    assign bus.Instruction      = instruction;
    assign bus.OP               = instruction[31:26];
    assign bus.InstrValid       = (state == VALID);
    assign bus.PC_plus4         = pcPlus4;
    assign bus.RetiredCount     = retiredCount;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table plus hand-written multi-cycle sequences for the fetch unit.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();
    instruction_fetch_unit_if bus2 ();

    instruction_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (.clk(clk), .reset(reset2), .bus(bus2));

    typedef struct {
        logic        rst, stall, ready, beq, bne, zero, jump;
        logic [31:0] data, off;
        logic [25:0] tgt;
        logic [31:0] expAddr, expInstr, expCount;
        logic        expValid;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic rst, stall, ready, input logic [31:0] data,
                                input logic beq, bne, zero, jump, input logic [31:0] off,
                                input logic [25:0] tgt, input logic [31:0] expAddr, expInstr,
                                input logic expValid, input logic [31:0] expCount);
        vec_t v;
        v.rst = rst; v.stall = stall; v.ready = ready; v.data = data;
        v.beq = beq; v.bne = bne; v.zero = zero; v.jump = jump; v.off = off; v.tgt = tgt;
        v.expAddr = expAddr; v.expInstr = expInstr; v.expValid = expValid; v.expCount = expCount;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, rdy, input logic [31:0] data);
        bus.Stall = st; bus.InstrMem_Ready = rdy; bus.InstrMem_Data = data;
        bus.BranchEQ = 0; bus.BranchNE = 0; bus.Zero = 0; bus.Jump = 0;
        bus.BranchOffset = 0; bus.JumpTarget = 0;
    endtask

    initial begin
        reset = 1; reset2 = 1;
        drive(0, 0, 0);
        bus2.Stall = 0; bus2.InstrMem_Ready = 0; bus2.InstrMem_Data = 0;
        bus2.BranchEQ = 0; bus2.BranchNE = 0; bus2.Zero = 0; bus2.Jump = 0;
        bus2.BranchOffset = 0; bus2.JumpTarget = 0;

        //           rst st rdy data          beq bne z  j  off           tgt         addr          instr         v  cnt
        vecs[0]  = mk(1, 0, 1, 32'hAAAAAAAA, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400000, 32'h00000000, 0, 0);
        vecs[1]  = mk(0, 0, 1, 32'h11111111, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400000, 32'h11111111, 1, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        26'h0,       32'h00400004, 32'h11111111, 0, 1);
        vecs[3]  = mk(0, 0, 1, 32'h22222222, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400004, 32'h22222222, 1, 1);
        vecs[4]  = mk(0, 0, 1, 32'h99999999, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400008, 32'h22222222, 0, 2);
        vecs[5]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        26'h0,       32'h00400008, 32'h22222222, 0, 2);
        vecs[6]  = mk(0, 0, 1, 32'h33333333, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400008, 32'h33333333, 1, 2);
        vecs[7]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        26'h0,       32'h0040000C, 32'h33333333, 0, 3);
        vecs[8]  = mk(0, 0, 1, 32'h10000000, 1, 0, 1, 1, 32'h7,        26'h3,       32'h0040000C, 32'h10000000, 1, 3);
        vecs[9]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        26'h0,       32'h00400010, 32'h10000000, 0, 4);
        vecs[10] = mk(0, 0, 1, 32'h10220003, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400010, 32'h10220003, 1, 4);
        vecs[11] = mk(0, 0, 0, 32'h0,        1, 0, 1, 0, 32'hFFFFFFFE, 26'h0,       32'h0040000C, 32'h10220003, 0, 5);
        vecs[12] = mk(0, 0, 1, 32'h55555555, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0040000C, 32'h55555555, 1, 5);
        vecs[13] = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        26'h0,       32'h00400010, 32'h55555555, 0, 6);
        vecs[14] = mk(0, 0, 1, 32'h66666666, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400010, 32'h66666666, 1, 6);
        vecs[15] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'hFFFFFFFE, 26'h0,       32'h00400014, 32'h66666666, 0, 7);
        vecs[16] = mk(0, 1, 1, 32'h08000000, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400014, 32'h08000000, 1, 7);
        vecs[17] = mk(0, 0, 0, 32'h0,        0, 1, 0, 1, 32'h5,        26'h0100008, 32'h00400020, 32'h08000000, 0, 8);
        vecs[18] = mk(0, 0, 1, 32'h20080005, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400020, 32'h20080005, 1, 8);
        vecs[19] = mk(0, 1, 1, 32'hDEADBEEF, 1, 1, 1, 1, 32'h9,        26'h5,       32'h00400020, 32'h20080005, 1, 8);
        vecs[20] = mk(0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h3,        26'h0,       32'h00400030, 32'h20080005, 0, 9);
        vecs[21] = mk(0, 0, 1, 32'h44444444, 0, 0, 0, 0, 32'h0,        26'h0,       32'h00400030, 32'h44444444, 1, 9);
        vecs[22] = mk(0, 0, 0, 32'h0,        1, 1, 1, 0, 32'h1,        26'h0,       32'h00400038, 32'h44444444, 0, 10);

        for (int i = 0; i < 23; i++) begin
            reset = vecs[i].rst;
            bus.Stall = vecs[i].stall; bus.InstrMem_Ready = vecs[i].ready; bus.InstrMem_Data = vecs[i].data;
            bus.BranchEQ = vecs[i].beq; bus.BranchNE = vecs[i].bne; bus.Zero = vecs[i].zero;
            bus.Jump = vecs[i].jump; bus.BranchOffset = vecs[i].off; bus.JumpTarget = vecs[i].tgt;
            step();
            check($sformatf("v%0d addr", i), bus.InstrMem_Address, vecs[i].expAddr);
            check($sformatf("v%0d instr", i), bus.Instruction, vecs[i].expInstr);
            check($sformatf("v%0d op", i), {26'd0, bus.OP}, {26'd0, vecs[i].expInstr[31:26]});
            check($sformatf("v%0d valid", i), {31'd0, bus.InstrValid}, {31'd0, vecs[i].expValid});
            check($sformatf("v%0d count", i), bus.RetiredCount, vecs[i].expCount);
            check($sformatf("v%0d pcplus4", i), bus.PC_plus4, vecs[i].expAddr + 32'd4);
            if (i == 0) reset2 = 0;
        end

        // Stall hold: presented word and count frozen for four stalled cycles, one retire on release.
        drive(0, 1, 32'h20080005);
        step();
        check("hold fetch valid", {31'd0, bus.InstrValid}, 32'd1);
        drive(1, 1, 32'hCAFEF00D);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("hold%0d instr", k), bus.Instruction, 32'h20080005);
            check($sformatf("hold%0d op", k), {26'd0, bus.OP}, 32'h8);
            check($sformatf("hold%0d valid", k), {31'd0, bus.InstrValid}, 32'd1);
            check($sformatf("hold%0d count", k), bus.RetiredCount, 32'd10);
            check($sformatf("hold%0d addr", k), bus.InstrMem_Address, 32'h00400038);
        end
        drive(0, 0, 0);
        step();
        check("hold release count", bus.RetiredCount, 32'd11);
        check("hold release valid", {31'd0, bus.InstrValid}, 32'd0);
        check("hold release addr", bus.InstrMem_Address, 32'h0040003C);

        // Reset while VALID with Ready high.
        drive(0, 1, 32'h77777777);
        step();
        check("rstvalid pre valid", {31'd0, bus.InstrValid}, 32'd1);
        reset = 1;
        step();
        check("rstvalid valid", {31'd0, bus.InstrValid}, 32'd0);
        check("rstvalid addr", bus.InstrMem_Address, 32'h00400000);
        check("rstvalid count", bus.RetiredCount, 32'd0);
        check("rstvalid instr", bus.Instruction, 32'd0);

        // Reset mid-fetch: memory slow for two cycles, ready arrives in the reset cycle.
        reset = 0;
        drive(0, 0, 0);
        step();
        step();
        check("midfetch wait valid", {31'd0, bus.InstrValid}, 32'd0);
        reset = 1;
        drive(0, 1, 32'hBBBBBBBB);
        step();
        check("midfetch valid", {31'd0, bus.InstrValid}, 32'd0);
        check("midfetch addr", bus.InstrMem_Address, 32'h00400000);
        check("midfetch count", bus.RetiredCount, 32'd0);
        check("midfetch instr", bus.Instruction, 32'd0);
        reset = 0;
        drive(0, 1, 32'h12345678);
        step();
        check("postrst valid", {31'd0, bus.InstrValid}, 32'd1);
        check("postrst instr", bus.Instruction, 32'h12345678);

        // PC wrap from the top of the address space.
        check("wrap reset addr", bus2.InstrMem_Address, 32'hFFFFFFFC);
        check("wrap reset pcplus4", bus2.PC_plus4, 32'h00000000);
        bus2.InstrMem_Ready = 1; bus2.InstrMem_Data = 32'h00000001;
        step();
        check("wrap valid", {31'd0, bus2.InstrValid}, 32'd1);
        bus2.InstrMem_Ready = 0;
        step();
        check("wrap addr", bus2.InstrMem_Address, 32'h00000000);
        check("wrap count", bus2.RetiredCount, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0040_0000, giving the PC value loaded on reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Stall  input  1  consumer not ready; hold the presented instruction.
REQ-006 BranchEQ, BranchNE  input  1 each  branch controls decoded from the presented instruction.
REQ-007 Zero  input  1  ALU zero flag for the presented instruction.
REQ-008 Jump  input  1  unconditional jump for the presented instruction.
REQ-009 BranchOffset  input  32  sign-extended immediate (word units).
REQ-010 JumpTarget  input  26  jump index field.
REQ-011 InstrMem_Data  input  32  instruction memory read data.
REQ-012 InstrMem_Ready  input  1  read data valid this cycle.
REQ-013 InstrMem_Address  output  32  current PC, low two bits always 0.
REQ-014 Instruction  output  32  registered instruction.
REQ-015 OP  output  6  Instruction[31:26], feeds the control unit.
REQ-016 InstrValid  output  1  Instruction holds a fetched word.
REQ-017 PC_plus4  output  32  PC + 4 of the presented instruction.
REQ-018 RetiredCount  output  32  number of instructions accepted.

Function
REQ-019 The block SHALL implement two states, FETCH and VALID, held in a registered state variable.
REQ-020 In FETCH, the block SHALL drive InstrMem_Address = PC and SHALL hold InstrValid at 0.
REQ-021 In FETCH, on a rising edge with InstrMem_Ready=1, the block SHALL capture InstrMem_Data into Instruction, set InstrValid=1, and enter VALID.
REQ-022 The minimum fetch latency SHALL be 1 cycle after entering FETCH; there SHALL be no upper bound.
REQ-023 In FETCH, Stall SHALL be ignored.
REQ-024 In VALID with Stall=1, the block SHALL hold PC, Instruction, InstrValid and RetiredCount unchanged.
REQ-025 In VALID with Stall=0, the instruction is accepted: on that edge the block SHALL load PC with NextPC, increment RetiredCount, clear InstrValid, and return to FETCH.
REQ-026 Taken SHALL equal (BranchEQ & Zero) | (BranchNE & ~Zero); if BranchEQ and BranchNE are both 1, Taken SHALL be 1.
REQ-027 NextPC priority SHALL be: Jump -> {PC_plus4[31:28], JumpTarget, 2'b00}; else Taken -> PC_plus4 + (BranchOffset << 2); else PC_plus4.
REQ-028 All PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0; branch sums SHALL wrap without saturation.
REQ-029 BranchEQ, BranchNE, Jump, Zero, BranchOffset and JumpTarget SHALL be sampled only on the accept edge, and ignored otherwise.
REQ-030 InstrMem_Ready asserted in VALID SHALL be ignored.
REQ-031 RetiredCount SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-032 On reset, the block SHALL set PC = RESET_PC, state = FETCH, Instruction = 0, InstrValid = 0 and RetiredCount = 0.
REQ-033 Reset SHALL take priority over all other inputs; InstrMem_Ready in the reset cycle SHALL be discarded, including mid-fetch and while in VALID.
REQ-034 OP and PC_plus4 SHALL derive combinationally from the registered values (after reset: OP = 0, PC_plus4 = RESET_PC + 4).

Verification
REQ-035 Sequential fetch: reset, Ready=1 every cycle, Stall=0, no branch/jump -> addresses 0x00400000, 0x00400004, 0x00400008 on alternating FETCH cycles; RetiredCount = 3 after three accepts.
REQ-036 Stall hold: instruction 0x20080005 presented, Stall=1 for 4 cycles, then 0 -> Instruction and OP (6'h08) stable for 4 cycles, InstrValid=1, single RetiredCount increment.
REQ-037 Branch: PC=0x00400010, BranchEQ=1, Zero=1, BranchOffset=32'hFFFF_FFFE -> next address 0x0040000C; same case with Zero=0 -> 0x00400014.
REQ-038 Jump over branch: Jump=1, JumpTarget=26'h0100008, BranchNE=1, Zero=0 -> next address 0x00400020.
REQ-039 Wrap: RESET_PC=32'hFFFF_FFFC, one accept with no branch -> next address 0x00000000.
REQ-040 Reset mid-fetch: Ready delayed 3 cycles, reset asserted in cycle 2 with Ready=1 -> InstrValid stays 0, PC = RESET_PC, RetiredCount = 0.
